// File: rtl/als_pkg.sv
// Shared constants for the ambient-light BCD display: frame field layout,
// seven-segment codes and the converter state encoding.
package als_pkg;

    // Light value position inside the 16-bit ADC frame
    localparam int DATA_MSB = 12;
    localparam int DATA_LSB = 5;

    // Bits that must read as zero in a well-formed frame ([15:13] and [3:0])
    localparam logic [15:0] ZERO_MASK = 16'hE00F;

    // Active-low segment codes, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Double-dabble converter states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after
    // the next doubling, so pre-add 3 to push the carry into the next digit.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder with blanking.
// Non-decimal nibbles (10..15) are shown as blank.
module bcd_to_seg
    import als_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Decode the nibble unless the digit is suppressed
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/als_bcd_display.sv
// Samples the PmodALS frame at a fixed rate, validates it, converts the 8-bit
// light value to three BCD digits with a serial double-dabble, and scans the
// digits onto a multiplexed active-low seven-segment display.
module als_bcd_display
    import als_pkg::*;
#(
    parameter int SAMPLE_DIV  = 100000,
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sw,
    input  logic [15:0] frame,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  value,
    output logic        busy,
    output logic        fmt_err
);

    localparam int SCW = (SAMPLE_DIV  > 1) ? $clog2(SAMPLE_DIV)  : 1;
    localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SCW-1:0] SMP_LAST = SCW'(SAMPLE_DIV - 1);
    localparam logic [RCW-1:0] REF_LAST = RCW'(REFRESH_DIV - 1);

    // Sample tick counter
    logic [SCW-1:0] smp_cnt_q, smp_cnt_d;
    logic           tick;

    // Converter state
    state_t         state_q, state_d;
    logic [19:0]    dd_q, dd_d;        // {hundreds, tens, ones, bin} shift register
    logic [19:0]    dd_adj;
    logic [7:0]     cap_q, cap_d;      // captured light value, kept for the load
    logic [2:0]     iter_q, iter_d;
    logic           busy_q, busy_d;
    logic           fmt_err_q, fmt_err_d;
    logic [7:0]     value_q, value_d;
    logic [3:0]     hund_q, hund_d;
    logic [3:0]     tens_q, tens_d;
    logic [3:0]     ones_q, ones_d;
    logic           frame_ok;

    // Display scan
    logic [RCW-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0]     an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic [3:0]     nib_sel;
    logic           blank_sel;
    logic [6:0]     seg_code;

    // Bit 4 of the frame carries no information
    logic           unused_frame_bit;
    assign unused_frame_bit = frame[4];

    assign frame_ok = ((frame & ZERO_MASK) == 16'h0000);
    assign tick     = (smp_cnt_q == SMP_LAST);

    // Free-running sample counter; keeps running while the display is frozen
    always_comb begin
        smp_cnt_d = tick ? '0 : (smp_cnt_q + SCW'(1));
    end

    // Converter next state: capture on tick, eight shift iterations, then load
    always_comb begin
        state_d   = state_q;
        dd_d      = dd_q;
        cap_d     = cap_q;
        iter_d    = iter_q;
        busy_d    = busy_q;
        fmt_err_d = 1'b0;
        value_d   = value_q;
        hund_d    = hund_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        dd_adj    = {add3(dd_q[19:16]), add3(dd_q[15:12]), add3(dd_q[11:8]), dd_q[7:0]};
        case (state_q)
            ST_IDLE: begin
                if (tick && sw) begin
                    if (frame_ok) begin
                        cap_d   = frame[DATA_MSB:DATA_LSB];
                        dd_d    = {12'h000, frame[DATA_MSB:DATA_LSB]};
                        iter_d  = 3'd0;
                        busy_d  = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        fmt_err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                dd_d   = dd_adj << 1;
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                hund_d  = dd_q[19:16];
                tens_d  = dd_q[15:12];
                ones_d  = dd_q[11:8];
                value_d = cap_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scan next state: advance digit index at refresh wrap and pick its anode/digit
    always_comb begin
        ref_cnt_d = (ref_cnt_q == REF_LAST) ? '0 : (ref_cnt_q + RCW'(1));
        idx_d     = idx_q;
        if (ref_cnt_q == REF_LAST) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : (idx_q + 2'd1);
        end
        nib_sel   = ones_q;
        blank_sel = 1'b0;
        an_d      = 4'b1110;
        case (idx_d)
            2'd1: begin
                nib_sel   = tens_q;
                blank_sel = (hund_q == 4'd0) && (tens_q == 4'd0);
                an_d      = 4'b1101;
            end
            2'd2: begin
                nib_sel   = hund_q;
                blank_sel = (hund_q == 4'd0);
                an_d      = 4'b1011;
            end
            default: begin
                nib_sel   = ones_q;
                blank_sel = 1'b0;
                an_d      = 4'b1110;
            end
        endcase
        seg_d = seg_code;
    end

    bcd_to_seg u_bcd_to_seg (
        .nibble (nib_sel),
        .blank  (blank_sel),
        .seg    (seg_code)
    );

    // State registers; reset abandons any conversion and blanks the display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_cnt_q <= '0;
            state_q   <= ST_IDLE;
            dd_q      <= '0;
            cap_q     <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            fmt_err_q <= 1'b0;
            value_q   <= '0;
            hund_q    <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            ref_cnt_q <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            smp_cnt_q <= smp_cnt_d;
            state_q   <= state_d;
            dd_q      <= dd_d;
            cap_q     <= cap_d;
            iter_q    <= iter_d;
            busy_q    <= busy_d;
            fmt_err_q <= fmt_err_d;
            value_q   <= value_d;
            hund_q    <= hund_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = 1'b1;
    assign value   = value_q;
    assign busy    = busy_q;
    assign fmt_err = fmt_err_q;

endmodule

// File: tb/tb_als_bcd_display.sv
// Directed bench for als_bcd_display with SAMPLE_DIV=32, REFRESH_DIV=4.
// ecnt counts clock edges since reset release; the DUT sample counter
// therefore ticks in the cycle before edge 32*n and loads 9 edges later.
module tb_als_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sw = 1'b1;
    logic [15:0] frame = 16'h1FE0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  value;
    logic        busy;
    logic        fmt_err;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;

    als_bcd_display #(
        .SAMPLE_DIV  (32),
        .REFRESH_DIV (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .frame   (frame),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .value   (value),
        .busy    (busy),
        .fmt_err (fmt_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after edge number e
    task automatic goto(input int e);
        while (ecnt < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Watch 12 cycles of scanning; digit index follows (ecnt/4) mod 3
    task automatic scan_chk(input string tag, input logic [6:0] s_one,
                            input logic [6:0] s_ten, input logic [6:0] s_hun);
        logic [3:0] ea;
        logic [6:0] es;
        repeat (12) begin
            @(posedge clk);
            #1;
            case ((ecnt / 4) % 3)
                0:       begin ea = 4'b1110; es = s_one; end
                1:       begin ea = 4'b1101; es = s_ten; end
                default: begin ea = 4'b1011; es = s_hun; end
            endcase
            chk({tag, "_an"}, {12'h0, an}, {12'h0, ea});
            chk({tag, "_seg"}, {9'h0, seg}, {9'h0, es});
        end
    endtask

    initial begin
        int bcount;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_dp", {15'h0, dp}, 16'h0001);
        chk("rst_value", {8'h0, value}, 16'h0000);
        chk("rst_busy", {15'h0, busy}, 16'h0000);
        chk("rst_fmt_err", {15'h0, fmt_err}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // First clock after release drives the ones anode showing "0"
        goto(1);
        chk("first_an", {12'h0, an}, 16'h000E);
        chk("first_seg", {9'h0, seg}, 16'h0040);

        // 255: busy for 9 cycles, value at tick+10
        goto(31);
        chk("t1_value_pre", {8'h0, value}, 16'h0000);
        chk("t1_busy_pre", {15'h0, busy}, 16'h0000);
        bcount = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (busy) bcount++;
        end
        chk("t1_busy_cycles", 16'(bcount), 16'd9);
        chk("t1_value", {8'h0, value}, 16'h00FF);
        chk("t1_busy_post", {15'h0, busy}, 16'h0000);
        goto(44);
        scan_chk("t1_scan", 7'b0010010, 7'b0010010, 7'b0100100);

        // 10: hundreds blanked, tens shown
        frame = 16'h0140;
        goto(72);
        chk("t2_value_pre", {8'h0, value}, 16'h00FF);
        goto(73);
        chk("t2_value", {8'h0, value}, 16'h000A);
        goto(76);
        scan_chk("t2_scan", 7'b1000000, 7'b1111001, 7'h7F);

        // Malformed frame: single fmt_err pulse, no conversion
        goto(90);
        frame = 16'h8005;
        goto(95);
        chk("t4_fmt_pre", {15'h0, fmt_err}, 16'h0000);
        goto(96);
        chk("t4_fmt_pulse", {15'h0, fmt_err}, 16'h0001);
        chk("t4_busy", {15'h0, busy}, 16'h0000);
        goto(97);
        chk("t4_fmt_post", {15'h0, fmt_err}, 16'h0000);
        chk("t4_busy_post", {15'h0, busy}, 16'h0000);
        goto(106);
        chk("t4_value", {8'h0, value}, 16'h000A);

        // 0: only the ones digit is lit
        goto(110);
        frame = 16'h0000;
        goto(136);
        chk("t3_value_pre", {8'h0, value}, 16'h000A);
        goto(137);
        chk("t3_value", {8'h0, value}, 16'h0000);
        goto(140);
        scan_chk("t3_scan", 7'b1000000, 7'h7F, 7'h7F);

        // Frozen: ticks at 160/192/224 ignored, then live again at 256
        goto(153);
        sw = 1'b0;
        frame = 16'h1FE0;
        goto(161);
        chk("frz_busy", {15'h0, busy}, 16'h0000);
        goto(233);
        chk("frz_value", {8'h0, value}, 16'h0000);
        goto(234);
        sw = 1'b1;
        goto(264);
        chk("live_value_pre", {8'h0, value}, 16'h0000);
        goto(265);
        chk("live_value", {8'h0, value}, 16'h00FF);

        // Reset mid-SHIFT (tick at edge 288)
        goto(291);
        chk("mid_busy", {15'h0, busy}, 16'h0001);
        rst = 1'b1;
        #1;
        chk("mid_rst_an", {12'h0, an}, 16'h000F);
        chk("mid_rst_seg", {9'h0, seg}, 16'h007F);
        chk("mid_rst_busy", {15'h0, busy}, 16'h0000);
        chk("mid_rst_value", {8'h0, value}, 16'h0000);
        chk("mid_rst_fmt", {15'h0, fmt_err}, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        goto(1);
        chk("rel_an", {12'h0, an}, 16'h000E);
        chk("rel_seg", {9'h0, seg}, 16'h0040);
        goto(4);
        scan_chk("rel_scan", 7'b1000000, 7'h7F, 7'h7F);
        goto(31);
        chk("rel_busy_pre", {15'h0, busy}, 16'h0000);
        goto(40);
        chk("rel_value_pre", {8'h0, value}, 16'h0000);
        goto(41);
        chk("rel_value", {8'h0, value}, 16'h00FF);
        chk("rel_dp", {15'h0, dp}, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
